// File: rtl/obstacle_sequencer.sv
// Game-side obstacle sequencer: picks the next obstacle from an LFSR, issues a
// one-cycle start token with its select code, and tracks rounds, win and loss.
module obstacle_sequencer #(
  parameter int unsigned NUM_OBSTACLES = 4,
  parameter int unsigned ROUNDS        = 8,
  parameter int unsigned GAP_CYCLES    = 65000000,
  parameter int unsigned START_TIMEOUT = 4,
  parameter logic [7:0]  LFSR_SEED     = 8'hA5
) (
  input  logic       pclk,
  input  logic       rst,
  input  logic       game_on,
  input  logic       menu_on,
  input  logic       play_selected,
  input  logic       working_in,
  input  logic       done_in,
  input  logic       collision,
  output logic [3:0] selected,
  output logic       done_out,
  output logic [7:0] round_count,
  output logic       game_over,
  output logic       win,
  output logic       busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_START,
    S_RUN,
    S_GAP,
    S_OVER
  } state_t;

  localparam logic [7:0]  NUM8    = 8'(NUM_OBSTACLES);
  localparam logic [3:0]  LAST4   = 4'(NUM_OBSTACLES - 1);
  localparam logic [7:0]  ROUNDS8 = 8'(ROUNDS);
  localparam logic [26:0] TO27    = 27'(START_TIMEOUT);
  localparam logic [26:0] GAP27   = 27'(GAP_CYCLES);

  state_t      state, state_nxt;
  logic [26:0] timer, timer_nxt, timer_inc;
  logic [7:0]  lfsr, lfsr_nxt;
  logic [3:0]  cand, next_code, selected_nxt;
  logic        done_nxt;
  logic [7:0]  rc_nxt, rc_inc;
  logic        game_over_nxt, win_nxt, busy_nxt;
  logic        abort, start_req;

  always_comb begin
    abort     = menu_on | ~play_selected;
    start_req = game_on & play_selected & ~menu_on;
    lfsr_nxt  = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
    timer_inc = timer + 27'd1;
    rc_inc    = (round_count == 8'hFF) ? 8'hFF : round_count + 8'd1;

    // Step past the previous code so the same obstacle never runs twice in a row.
    cand = 4'(lfsr % NUM8);
    if (cand == selected && round_count != 8'd0)
      next_code = (cand == LAST4) ? 4'd0 : cand + 4'd1;
    else
      next_code = cand;
  end

  always_comb begin
    state_nxt     = state;
    timer_nxt     = timer;
    selected_nxt  = selected;
    done_nxt      = 1'b0;
    rc_nxt        = round_count;
    game_over_nxt = game_over;
    win_nxt       = win;

    if (state == S_IDLE) begin
      if (start_req) begin
        rc_nxt        = '0;
        game_over_nxt = 1'b0;
        win_nxt       = 1'b0;
        state_nxt     = S_ISSUE;
      end
    end else if (abort) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_ISSUE: begin
          selected_nxt = next_code;
          done_nxt     = 1'b1;
          timer_nxt    = '0;
          state_nxt    = S_WAIT_START;
        end
        S_WAIT_START: begin
          if (working_in) begin
            state_nxt = S_RUN;
          end else if (timer_inc >= TO27) begin
            state_nxt = S_ISSUE;
          end else begin
            timer_nxt = timer_inc;
          end
        end
        S_RUN: begin
          if (collision) begin
            game_over_nxt = 1'b1;
            win_nxt       = 1'b0;
            state_nxt     = S_OVER;
          end else if (done_in) begin
            rc_nxt = rc_inc;
            if (rc_inc == ROUNDS8) begin
              game_over_nxt = 1'b1;
              win_nxt       = 1'b1;
              state_nxt     = S_OVER;
            end else begin
              timer_nxt = '0;
              state_nxt = S_GAP;
            end
          end
        end
        S_GAP: begin
          if (timer_inc >= GAP27)
            state_nxt = S_ISSUE;
          else
            timer_nxt = timer_inc;
        end
        S_OVER: begin
          game_over_nxt = 1'b1;
        end
        default: begin
          state_nxt = S_IDLE;
        end
      endcase
    end

    busy_nxt = (state_nxt != S_IDLE);
  end

  always_ff @(posedge pclk) begin
    if (rst) begin
      state       <= S_IDLE;
      timer       <= '0;
      lfsr        <= LFSR_SEED;
      selected    <= '0;
      done_out    <= 1'b0;
      round_count <= '0;
      game_over   <= 1'b0;
      win         <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state       <= state_nxt;
      timer       <= timer_nxt;
      lfsr        <= lfsr_nxt;
      selected    <= selected_nxt;
      done_out    <= done_nxt;
      round_count <= rc_nxt;
      game_over   <= game_over_nxt;
      win         <= win_nxt;
      busy        <= busy_nxt;
    end
  end

endmodule

// File: tb/tb_obstacle_sequencer.sv
// Directed bench for obstacle_sequencer: scenario table plus hand-written
// abort and reset sequences, with a model obstacle and a select-code model.
`timescale 1ns/1ps
module tb_obstacle_sequencer;

  localparam int unsigned NOBS = 4;
  localparam int unsigned NRND = 2;
  localparam int unsigned GAP  = 10;
  localparam int unsigned STO  = 4;

  logic       pclk = 1'b0;
  logic       rst = 1'b1;
  logic       game_on = 1'b0;
  logic       menu_on = 1'b0;
  logic       play_selected = 1'b0;
  logic       working_in, done_in, collision;
  logic [3:0] selected;
  logic       done_out;
  logic [7:0] round_count;
  logic       game_over, win, busy;

  int checks = 0;
  int failures = 0;

  always #5 pclk = ~pclk;

  obstacle_sequencer #(
    .NUM_OBSTACLES(NOBS),
    .ROUNDS(NRND),
    .GAP_CYCLES(GAP),
    .START_TIMEOUT(STO),
    .LFSR_SEED(8'hA5)
  ) dut (
    .pclk(pclk),
    .rst(rst),
    .game_on(game_on),
    .menu_on(menu_on),
    .play_selected(play_selected),
    .working_in(working_in),
    .done_in(done_in),
    .collision(collision),
    .selected(selected),
    .done_out(done_out),
    .round_count(round_count),
    .game_over(game_over),
    .win(win),
    .busy(busy)
  );

  // Model obstacle: registers the token, raises working a cycle later, done on the last working cycle.
  logic        obs_en = 1'b0;
  int          coll_mode = 0;
  logic        coll_force = 1'b0;
  logic        tok_d, obs_working, obs_done;
  int unsigned obs_cnt;

  assign obs_done   = obs_working && (obs_cnt == 19);
  assign working_in = obs_working;
  assign done_in    = obs_done;
  assign collision  = coll_force | ((coll_mode == 1) && obs_working && (obs_cnt == 5))
                                 | ((coll_mode == 2) && obs_done);

  always @(posedge pclk) begin
    if (rst) begin
      tok_d       <= 1'b0;
      obs_working <= 1'b0;
      obs_cnt     <= 0;
    end else begin
      tok_d <= done_out & obs_en;
      if (tok_d) begin
        obs_working <= 1'b1;
        obs_cnt     <= 0;
      end else if (obs_working) begin
        if (obs_cnt == 19) obs_working <= 1'b0;
        else obs_cnt <= obs_cnt + 1;
      end
    end
  end

  // Select-code model: LFSR plus a flag for "a round has completed this game".
  logic [7:0] m_lfsr, m_lfsr_prev;
  logic       m_rc_nz;
  int         game_id = 0;
  int         m_game_seen = 0;

  function automatic logic [7:0] lfsr_step(input logic [7:0] v);
    return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
  endfunction

  always @(posedge pclk) begin
    m_lfsr_prev <= m_lfsr;
    m_game_seen <= game_id;
    if (rst) begin
      m_lfsr  <= 8'hA5;
      m_rc_nz <= 1'b0;
    end else begin
      m_lfsr <= lfsr_step(m_lfsr);
      if (game_id != m_game_seen) m_rc_nz <= 1'b0;
      else if (obs_done && !collision && !menu_on && play_selected) m_rc_nz <= 1'b1;
    end
  end

  // Token monitor: code, width and reissue interval of every token.
  int         tok_cnt = 0;
  int         cyc = 0;
  int         last_tok = -1;
  int         mon_game = 0;
  logic       prev_done = 1'b0;
  logic [3:0] m_sel = 4'd0;
  logic [3:0] exp_code;

  always @(negedge pclk) begin
    cyc++;
    if (rst) begin
      m_sel     = 4'd0;
      prev_done = 1'b0;
      last_tok  = -1;
    end else begin
      if (mon_game != game_id) begin
        mon_game = game_id;
        last_tok = -1;
      end
      if (done_out) begin
        tok_cnt++;
        exp_code = 4'(m_lfsr_prev % 8'(NOBS));
        if (exp_code == m_sel && m_rc_nz)
          exp_code = (exp_code == 4'(NOBS - 1)) ? 4'd0 : exp_code + 4'd1;
        checks++;
        if (selected !== exp_code) begin
          failures++;
          $display("FAIL token_code: got %0d expected %0d", selected, exp_code);
        end
        checks++;
        if (prev_done !== 1'b0) begin
          failures++;
          $display("FAIL token_width: done_out high on consecutive cycles, expected single cycle");
        end
        if (!obs_en && last_tok >= 0) begin
          checks++;
          if (cyc - last_tok != int'(STO + 1)) begin
            failures++;
            $display("FAIL reissue_interval: got %0d expected %0d", cyc - last_tok, STO + 1);
          end
        end
        last_tok = cyc;
        m_sel    = exp_code;
      end
      prev_done = done_out;
    end
  end

  task automatic chk(input string name, input int unsigned act, input int unsigned exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge pclk);
    rst = 1'b1; game_on = 1'b0; play_selected = 1'b0; menu_on = 1'b0; coll_force = 1'b0;
    repeat (2) @(negedge pclk);
    rst = 1'b0;
    repeat (3) @(negedge pclk);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_selected"}, 32'(selected), 0);
    chk({tag, "_done_out"}, 32'(done_out), 0);
    chk({tag, "_round_count"}, 32'(round_count), 0);
    chk({tag, "_game_over"}, 32'(game_over), 0);
    chk({tag, "_win"}, 32'(win), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
  endtask

  typedef struct {
    bit          obs_en;
    int          coll_mode;
    bit          menu;
    int unsigned cycles;
    int unsigned exp_tokens;
    int unsigned exp_rc;
    int unsigned exp_over;
    int unsigned exp_win;
    int unsigned exp_busy;
  } vec_t;

  vec_t       vec [5];
  int         t0;
  bit         ok;
  logic [3:0] c1, c2;

  initial begin
    // obs, coll, menu, cycles, tokens, rc, over, win, busy
    vec[0] = '{1'b1, 0, 1'b0, 80, 2, 2, 1, 1, 1};  // two rounds survived
    vec[1] = '{1'b1, 1, 1'b0, 80, 1, 0, 1, 0, 1};  // collision in first run
    vec[2] = '{1'b0, 0, 1'b0, 40, 8, 0, 0, 0, 1};  // obstacle never starts
    vec[3] = '{1'b1, 2, 1'b0, 80, 1, 0, 1, 0, 1};  // collision with done
    vec[4] = '{1'b1, 0, 1'b1, 30, 0, 0, 0, 0, 0};  // menu blocks start

    for (int i = 0; i < 5; i++) begin
      obs_en    = vec[i].obs_en;
      coll_mode = vec[i].coll_mode;
      do_reset();
      chk_reset_vals($sformatf("row%0d_reset", i));
      t0 = tok_cnt;
      game_id++;
      game_on = 1'b1; play_selected = 1'b1; menu_on = vec[i].menu;
      repeat (vec[i].cycles) @(negedge pclk);
      chk($sformatf("row%0d_tokens", i), 32'(tok_cnt - t0), vec[i].exp_tokens);
      chk($sformatf("row%0d_round_count", i), 32'(round_count), vec[i].exp_rc);
      chk($sformatf("row%0d_game_over", i), 32'(game_over), vec[i].exp_over);
      chk($sformatf("row%0d_win", i), 32'(win), vec[i].exp_win);
      chk($sformatf("row%0d_busy", i), 32'(busy), vec[i].exp_busy);
      chk($sformatf("row%0d_sel_range", i), 32'(selected < 4'(NOBS)), 1);
    end

    // Reset in the middle of RUN, then the first code must repeat.
    obs_en = 1'b1; coll_mode = 0;
    do_reset();
    t0 = tok_cnt; game_id++;
    game_on = 1'b1; play_selected = 1'b1;
    ok = 1'b0;
    for (int k = 0; k < 30; k++) begin
      @(negedge pclk);
      if (tok_cnt > t0) begin ok = 1'b1; break; end
    end
    chk("rst_first_token_seen", 32'(ok), 1);
    c1 = selected;
    ok = 1'b0;
    for (int k = 0; k < 30; k++) begin
      @(negedge pclk);
      if (working_in) begin ok = 1'b1; break; end
    end
    chk("rst_reach_run", 32'(ok), 1);
    repeat (3) @(negedge pclk);
    rst = 1'b1;
    @(negedge pclk);
    chk_reset_vals("mid_run_rst");
    do_reset();
    t0 = tok_cnt; game_id++;
    game_on = 1'b1; play_selected = 1'b1;
    ok = 1'b0;
    for (int k = 0; k < 30; k++) begin
      @(negedge pclk);
      if (tok_cnt > t0) begin ok = 1'b1; break; end
    end
    chk("rst_second_token_seen", 32'(ok), 1);
    c2 = selected;
    chk("same_first_code", 32'(c2), 32'(c1));

    // Abort during GAP, restart, then abort during RUN.
    do_reset();
    game_id++;
    game_on = 1'b1; play_selected = 1'b1;
    ok = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(negedge pclk);
      if (round_count == 8'd1) begin ok = 1'b1; break; end
    end
    chk("abort_reach_gap", 32'(ok), 1);
    repeat (2) @(negedge pclk);
    menu_on = 1'b1;
    @(negedge pclk);
    chk("gap_abort_busy", 32'(busy), 0);
    chk("gap_abort_done_out", 32'(done_out), 0);
    chk("gap_abort_rc_held", 32'(round_count), 1);
    t0 = tok_cnt;
    repeat (15) @(negedge pclk);
    chk("gap_abort_no_token", 32'(tok_cnt - t0), 0);
    menu_on = 1'b0; game_id++;
    @(negedge pclk);
    chk("restart_rc_cleared", 32'(round_count), 0);
    chk("restart_busy", 32'(busy), 1);
    ok = 1'b0;
    for (int k = 0; k < 30; k++) begin
      @(negedge pclk);
      if (working_in) begin ok = 1'b1; break; end
    end
    chk("restart_reach_run", 32'(ok), 1);
    repeat (3) @(negedge pclk);
    menu_on = 1'b1;
    @(negedge pclk);
    chk("run_abort_busy", 32'(busy), 0);
    chk("run_abort_done_out", 32'(done_out), 0);
    play_selected = 1'b0; menu_on = 1'b0;
    t0 = tok_cnt;
    repeat (30) @(negedge pclk);
    chk("run_abort_no_token", 32'(tok_cnt - t0), 0);
    chk("run_abort_idle", 32'(busy), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
